// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to the I$. Define IMEM_LOADER_CHECKSUM_EN for o_checksum.
module imem_loader #(
  parameter int                AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [15:0]       i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_icache_rq,
  output logic              o_icache_rnw,
  output logic [AWIDTH-1:0] o_icache_addr,
  output logic [31:0]       o_icache_wdata,
  output logic              o_core_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] last_addr_q, last_addr_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic              start_accept;

  assign start_accept = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      addr_q      <= BASE_ADDR;
      last_addr_q <= BASE_ADDR;
      word_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    word_d      = word_q;
    idx_d       = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          if (i_num_words != 16'd0) begin
            state_d = S_RECV;
            count_d = i_num_words;
            addr_d  = BASE_ADDR;
            idx_d   = 2'd0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RECV: begin
        if (i_byte_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = i_byte;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // the address seen outside WRITE is the one just written
        last_addr_d = addr_q;
        count_d     = count_q - 16'd1;
        if (count_q == 16'd1) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + AWIDTH'(4);
          state_d = S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_byte_ready   = (state_q == S_RECV);
  assign o_icache_rq    = (state_q == S_WRITE);
  assign o_icache_rnw   = (state_q != S_WRITE);
  assign o_icache_addr  = (state_q == S_WRITE) ? addr_q : last_addr_q;
  assign o_icache_wdata = (state_q == S_WRITE) ? word_q : 32'h0;
  assign o_core_reset   = (state_q != S_DONE);
  assign o_busy         = (state_q == S_RECV) || (state_q == S_WRITE);
  assign o_done         = (state_q == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  always_comb begin
    sum_d = sum_q;
    if (start_accept)            sum_d = 32'h0;
    else if (state_q == S_WRITE) sum_d = sum_q + word_q;
  end

  assign o_checksum = sum_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign o_checksum = 32'h0;
`endif

endmodule
